// File: rtl/iir_pkg.sv
// Shared constants, FSM state type and saturation helpers for the biquad cascade.
package iir_pkg;

    localparam int COEFS_PER_SECTION = 5;

    localparam logic [2:0] K_B0 = 3'd0;
    localparam logic [2:0] K_B1 = 3'd1;
    localparam logic [2:0] K_B2 = 3'd2;
    localparam logic [2:0] K_A1 = 3'd3;
    localparam logic [2:0] K_A2 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_SAT  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    function automatic logic signed [127:0] sat_max(input int width);
        sat_max = (128'sd1 <<< (width - 1)) - 128'sd1;
    endfunction

    function automatic logic signed [127:0] sat_min(input int width);
        sat_min = -(128'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/iir_biquad_cascade_if.sv
// Sample stream, result stream and coefficient bus of the biquad cascade.
interface iir_biquad_cascade_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 32,
    parameter int ADDR_W = 5
);
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_data;
    logic                     coef_we;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     coef_ready;
    logic                     clear_state;

    modport slave (
        input  s_valid, s_data, m_ready, coef_we, coef_addr, coef_wdata, clear_state,
        output s_ready, m_valid, m_data, coef_ready
    );

    modport master (
        output s_valid, s_data, m_ready, coef_we, coef_addr, coef_wdata, clear_state,
        input  s_ready, m_valid, m_data, coef_ready
    );
endinterface

// File: rtl/biquad_mac.sv
// Shared multiply-accumulate: registered product, delayed accumulate, then
// arithmetic shift and clamp of the running sum to the internal sample range.
module biquad_mac
    import iir_pkg::*;
#(
    parameter int COEF_W = 32,
    parameter int SAMP_W = 32,
    parameter int FRAC_W = 16,
    parameter int ACC_W  = 68
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [SAMP_W-1:0] samp,
    input  logic                     acc_clr,
    input  logic                     acc_en,
    input  logic                     sub,
    output logic signed [SAMP_W-1:0] y_sat
);
    localparam int PROD_W = COEF_W + SAMP_W;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(SAMP_W));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(SAMP_W));

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  prod_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic                     en_d_reg;
    logic                     clr_d_reg;

    assign prod     = coef * samp;
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    // The product lands one cycle after its operands, so the clear travels with it;
    // sum therefore already includes the last term while the FSM sits in SAT.
    assign sum = (clr_d_reg ? {ACC_W{1'b0}} : acc_reg) + prod_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prod_reg  <= '0;
            acc_reg   <= '0;
            en_d_reg  <= 1'b0;
            clr_d_reg <= 1'b0;
        end else begin
            en_d_reg  <= acc_en;
            clr_d_reg <= acc_clr;
            if (acc_en) begin
                prod_reg <= sub ? -prod_ext : prod_ext;
            end
            if (en_d_reg) begin
                acc_reg <= sum;
            end
        end
    end

    always_comb begin
        shifted = sum >>> FRAC_W;
        if (shifted > SAT_HI) begin
            y_sat = SAT_HI[SAMP_W-1:0];
        end else if (shifted < SAT_LO) begin
            y_sat = SAT_LO[SAMP_W-1:0];
        end else begin
            y_sat = shifted[SAMP_W-1:0];
        end
    end
endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of direct-form-I biquads sharing one MAC; coefficients and delay
// lines live in per-entry registers so reset and clear take a single cycle.
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int FRAC_W       = 16,
    parameter int COEF_W       = 32,
    parameter int NUM_SECTIONS = 4,
    parameter int ACC_W        = 68
) (
    input logic                 clk,
    input logic                 resetn,
    iir_biquad_cascade_if.slave bus
);
    localparam int SAMP_W    = DATA_W + FRAC_W;
    localparam int NUM_COEFS = COEFS_PER_SECTION * NUM_SECTIONS;
    localparam int ADDR_W    = $clog2(NUM_COEFS);
    localparam int SEC_W     = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
    localparam logic signed [COEF_W-1:0] COEF_ONE =
        {{(COEF_W - FRAC_W - 1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

    state_t                   state_reg;
    state_t                   state_next;
    logic [2:0]               k_reg;
    logic [SEC_W-1:0]         sec_reg;
    logic                     last_sec;
    logic signed [SAMP_W-1:0] x_cur_reg;
    logic signed [DATA_W-1:0] m_data_reg;

    logic signed [COEF_W-1:0] coef_arr [NUM_COEFS];
    logic signed [SAMP_W-1:0] x1_arr [NUM_SECTIONS];
    logic signed [SAMP_W-1:0] x2_arr [NUM_SECTIONS];
    logic signed [SAMP_W-1:0] y1_arr [NUM_SECTIONS];
    logic signed [SAMP_W-1:0] y2_arr [NUM_SECTIONS];

    logic [ADDR_W-1:0]        coef_idx;
    logic signed [COEF_W-1:0] mac_coef;
    logic signed [SAMP_W-1:0] mac_samp;
    logic                     mac_sub;
    logic signed [SAMP_W-1:0] y_sat;
    logic                     in_idle;

    assign in_idle        = (state_reg == ST_IDLE);
    assign last_sec       = (sec_reg == SEC_W'(NUM_SECTIONS - 1));
    assign bus.s_ready    = in_idle;
    assign bus.coef_ready = in_idle;
    assign bus.m_valid    = (state_reg == ST_OUT);
    assign bus.m_data     = m_data_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (bus.s_valid) state_next = ST_MAC;
            ST_MAC:  if (k_reg == K_A2) state_next = ST_SAT;
            ST_SAT:  state_next = last_sec ? ST_OUT : ST_MAC;
            ST_OUT:  if (bus.m_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            k_reg      <= '0;
            sec_reg    <= '0;
            x_cur_reg  <= '0;
            m_data_reg <= '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    k_reg   <= '0;
                    sec_reg <= '0;
                    if (bus.s_valid) begin
                        x_cur_reg <= {bus.s_data, {FRAC_W{1'b0}}};
                    end
                end
                ST_MAC: begin
                    k_reg <= (k_reg == K_A2) ? 3'd0 : k_reg + 3'd1;
                end
                ST_SAT: begin
                    x_cur_reg <= y_sat;
                    if (last_sec) begin
                        m_data_reg <= y_sat[SAMP_W-1 -: DATA_W];
                    end else begin
                        sec_reg <= sec_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Writes only land in IDLE; addresses past the last section match no entry.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_COEFS; gi++) begin : g_coef
            logic signed [COEF_W-1:0] coef_reg;
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    coef_reg <= ((gi % COEFS_PER_SECTION) == 0) ? COEF_ONE : '0;
                end else if (in_idle && bus.coef_we && (bus.coef_addr == ADDR_W'(gi))) begin
                    coef_reg <= bus.coef_wdata;
                end
            end
            assign coef_arr[gi] = coef_reg;
        end

        for (gi = 0; gi < NUM_SECTIONS; gi++) begin : g_sec
            logic signed [SAMP_W-1:0] x1_reg;
            logic signed [SAMP_W-1:0] x2_reg;
            logic signed [SAMP_W-1:0] y1_reg;
            logic signed [SAMP_W-1:0] y2_reg;
            always_ff @(posedge clk) begin
                if (!resetn || (in_idle && bus.clear_state)) begin
                    x1_reg <= '0;
                    x2_reg <= '0;
                    y1_reg <= '0;
                    y2_reg <= '0;
                end else if (state_reg == ST_SAT && sec_reg == SEC_W'(gi)) begin
                    x2_reg <= x1_reg;
                    x1_reg <= x_cur_reg;
                    y2_reg <= y1_reg;
                    y1_reg <= y_sat;
                end
            end
            assign x1_arr[gi] = x1_reg;
            assign x2_arr[gi] = x2_reg;
            assign y1_arr[gi] = y1_reg;
            assign y2_arr[gi] = y2_reg;
        end
    endgenerate

    always_comb begin
        coef_idx = ADDR_W'(COEFS_PER_SECTION * int'(sec_reg) + int'(k_reg));
        mac_coef = coef_arr[coef_idx];
        mac_samp = '0;
        mac_sub  = 1'b0;
        case (k_reg)
            K_B0: mac_samp = x_cur_reg;
            K_B1: mac_samp = x1_arr[sec_reg];
            K_B2: mac_samp = x2_arr[sec_reg];
            K_A1: begin
                mac_samp = y1_arr[sec_reg];
                mac_sub  = 1'b1;
            end
            K_A2: begin
                mac_samp = y2_arr[sec_reg];
                mac_sub  = 1'b1;
            end
            default: ;
        endcase
    end

    biquad_mac #(
        .COEF_W (COEF_W),
        .SAMP_W (SAMP_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .resetn  (resetn),
        .coef    (mac_coef),
        .samp    (mac_samp),
        .acc_clr (k_reg == K_B0),
        .acc_en  (state_reg == ST_MAC),
        .sub     (mac_sub),
        .y_sat   (y_sat)
    );
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed vectors for the biquad cascade at default parameters, plus
// handshake, write-guard and mid-operation reset sequences.
module tb_iir_biquad_cascade;
    import iir_pkg::*;

    localparam int DATA_W = 16;
    localparam int COEF_W = 32;
    localparam int ADDR_W = 5;
    localparam int LAT    = 25;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    iir_biquad_cascade_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W)) bus ();

    iir_biquad_cascade dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                    name;
        bit                       we;
        logic [ADDR_W-1:0]        addr;
        logic [COEF_W-1:0]        cdata;
        bit                       clr;
        logic signed [DATA_W-1:0] din;
        logic signed [DATA_W-1:0] expv;
    } vec_t;

    vec_t vecs[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        total_cnt++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    task automatic add(input string n, input bit we, input int addr, input int cdata,
                       input bit clr, input int din, input int expv);
        vec_t v;
        v.name  = n;
        v.we    = we;
        v.addr  = addr[ADDR_W-1:0];
        v.cdata = cdata;
        v.clr   = clr;
        v.din   = din[DATA_W-1:0];
        v.expv  = expv[DATA_W-1:0];
        vecs.push_back(v);
    endtask

    // Presents one sample in IDLE and returns #1 after the accepting edge.
    task automatic start(input logic signed [DATA_W-1:0] din, input bit clr);
        bus.s_valid     = 1'b1;
        bus.s_data      = din;
        bus.clear_state = clr;
        @(posedge clk); #1;
        bus.s_valid     = 1'b0;
        bus.clear_state = 1'b0;
        bus.coef_we     = 1'b0;
    endtask

    // lat counts cycles with the accepting cycle as cycle 0.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.m_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic coef_write(input int addr, input int cdata);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = addr[ADDR_W-1:0];
        bus.coef_wdata = cdata;
        @(posedge clk); #1;
        bus.coef_we    = 1'b0;
    endtask

    initial begin
        int lat;
        bit saw_valid;
        bit held_ok;

        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        bus.m_ready     = 1'b1;
        bus.coef_we     = 1'b0;
        bus.coef_addr   = '0;
        bus.coef_wdata  = '0;
        bus.clear_state = 1'b0;

        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        chk("reset_s_ready", bus.s_ready, 1);
        chk("reset_coef_ready", bus.coef_ready, 1);
        chk("reset_m_valid", bus.m_valid, 0);
        chk("reset_m_data", bus.m_data, 0);

        //   name            we addr cdata    clr  din     expected
        add("pass_100",      0, 0,   0,       0,   100,    100);
        add("pass_min",      0, 0,   0,       0,   -32768, -32768);
        add("gain_half",     1, 0,   32768,   0,   1000,   500);
        add("gain_trunc",    0, 0,   0,       0,   -3,     -2);
        add("rec_0",         1, 0,   65536,   1,   1000,   1000);
        add("rec_1",         1, 3,   -32768,  0,   1000,   1500);
        add("rec_2",         0, 0,   0,       0,   1000,   1750);
        add("rec_3",         0, 0,   0,       0,   1000,   1875);
        add("rec_4",         0, 0,   0,       0,   1000,   1937);
        add("clear_restart", 0, 0,   0,       1,   1000,   1000);
        add("after_clear",   0, 0,   0,       0,   1000,   1500);
        add("a1_zero",       1, 3,   0,       0,   1000,   1000);
        add("sat_pos",       1, 0,   262144,  0,   20000,  32767);
        add("sat_neg",       0, 0,   0,       0,   -20000, -32768);
        add("unity_again",   1, 0,   65536,   0,   7,      7);
        add("addr_oob",      1, 20,  0,       0,   5,      5);

        foreach (vecs[i]) begin
            if (vecs[i].we) begin
                bus.coef_we    = 1'b1;
                bus.coef_addr  = vecs[i].addr;
                bus.coef_wdata = vecs[i].cdata;
            end
            start(vecs[i].din, vecs[i].clr);
            wait_out(lat);
            $display("vec %0d %s: in=%0d out=%0d lat=%0d", i, vecs[i].name,
                     vecs[i].din, $signed(bus.m_data), lat);
            chk({vecs[i].name, "_data"}, $signed(bus.m_data), vecs[i].expv);
            chk({vecs[i].name, "_lat"}, lat, LAT);
            @(posedge clk); #1;
        end

        // Coefficient write while busy must be dropped.
        start(10, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_coef_ready", bus.coef_ready, 0);
        coef_write(0, 2 * 65536);
        wait_out(lat);
        $display("busy_write: in=10 out=%0d lat=%0d", $signed(bus.m_data), lat);
        chk("busy_write_data", $signed(bus.m_data), 10);
        @(posedge clk); #1;
        start(11, 1'b0);
        wait_out(lat);
        $display("after_busy_write: in=11 out=%0d lat=%0d", $signed(bus.m_data), lat);
        chk("after_busy_write_data", $signed(bus.m_data), 11);
        @(posedge clk); #1;

        // Backpressure: output held for 10 cycles with input blocked.
        bus.m_ready = 1'b0;
        start(42, 1'b0);
        wait_out(lat);
        chk("bp_first_data", $signed(bus.m_data), 42);
        held_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (!bus.m_valid || bus.s_ready || bus.m_data != 16'sd42) held_ok = 1'b0;
        end
        $display("backpressure: out=%0d m_valid=%0d s_ready=%0d", $signed(bus.m_data),
                 bus.m_valid, bus.s_ready);
        chk("bp_hold_stable", held_ok, 1);
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_s_ready", bus.s_ready, 1);
        chk("bp_release_m_valid", bus.m_valid, 0);

        // Reset during section 2: sample discarded, coefficients back to unity.
        coef_write(0, 3 * 65536);
        start(50, 1'b0);
        repeat (13) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        chk("midrst_s_ready", bus.s_ready, 1);
        chk("midrst_m_data", bus.m_data, 0);
        saw_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.m_valid) saw_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("midrst_no_m_valid", saw_valid, 0);
        start(7, 1'b0);
        wait_out(lat);
        $display("post_reset: in=7 out=%0d lat=%0d", $signed(bus.m_data), lat);
        chk("post_reset_data", $signed(bus.m_data), 7);
        chk("post_reset_lat", lat, LAT);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
